// File: rtl/lru_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lru_refill_ctrl
// Description : Takes cache lookup results. A hit is reported to the LRU
//               straight away. A miss first captures the LRU victim way and
//               issues a refill request. The LRU update and the response are
//               sent once the refill data has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module lru_refill_ctrl #(
    parameter int ASSOCIATIVITY = 4,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = 8,
    parameter int OUTPUT_BITS   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [INDEX_BITS-1:0]  req_index,
    input  logic                   req_hit,
    input  logic [OUTPUT_BITS-1:0] req_hit_way,
    output logic [INDEX_BITS-1:0]  lru_line_selector,
    input  logic [OUTPUT_BITS-1:0] lru_way,
    output logic                   lru_update,
    output logic [OUTPUT_BITS-1:0] lru_referenced_set,
    output logic                   refill_valid,
    input  logic                   refill_ready,
    output logic [INDEX_BITS-1:0]  refill_index,
    output logic [OUTPUT_BITS-1:0] refill_way,
    input  logic                   refill_done,
    output logic                   resp_valid,
    output logic [OUTPUT_BITS-1:0] resp_way,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    // A way number must be able to name every way, and an index every line.
    if ((ASSOCIATIVITY > (1 << OUTPUT_BITS)) || (ENTRIES > (1 << INDEX_BITS))) begin : g_bad_params
        $error("lru_refill_ctrl: OUTPUT_BITS/INDEX_BITS too narrow for ASSOCIATIVITY/ENTRIES");
    end

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_REFILL_REQ  = 2'd1,
        S_REFILL_WAIT = 2'd2,
        S_UPDATE      = 2'd3
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t                 r_state;
    logic [INDEX_BITS-1:0]  r_index;
    logic [OUTPUT_BITS-1:0] r_way;
    logic                   r_req_ready;
    logic                   r_refill_valid;
    logic                   r_lru_update;
    logic                   r_resp_valid;
    logic [15:0]            r_hit_count;
    logic [15:0]            r_miss_count;
    logic                   w_accept;

    // Acceptance can only happen in IDLE, which is when req_ready is high.
    assign w_accept = req_valid & r_req_ready;

    // Control FSM. All status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_index        <= '0;
            r_way          <= '0;
            r_req_ready    <= 1'b1;
            r_refill_valid <= 1'b0;
            r_lru_update   <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            r_lru_update <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_index     <= req_index;
                        r_req_ready <= 1'b0;
                        if (req_hit) begin
                            r_way        <= req_hit_way;
                            r_state      <= S_UPDATE;
                            r_lru_update <= 1'b1;
                            r_resp_valid <= 1'b1;
                            if (r_hit_count != c_CNT_MAX) begin
                                r_hit_count <= r_hit_count + 16'd1;
                            end
                        end else begin
                            // Victim comes from the LRU read port addressed by req_index this cycle.
                            r_way          <= lru_way;
                            r_state        <= S_REFILL_REQ;
                            r_refill_valid <= 1'b1;
                            if (r_miss_count != c_CNT_MAX) begin
                                r_miss_count <= r_miss_count + 16'd1;
                            end
                        end
                    end
                end
                S_REFILL_REQ: begin
                    // A refill_done seen here belongs to no request of ours and is dropped.
                    if (refill_ready) begin
                        r_refill_valid <= 1'b0;
                        r_state        <= S_REFILL_WAIT;
                    end
                end
                S_REFILL_WAIT: begin
                    if (refill_done) begin
                        r_state      <= S_UPDATE;
                        r_lru_update <= 1'b1;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_req_ready    <= 1'b1;
                    r_refill_valid <= 1'b0;
                end
            endcase
        end
    end

    // In IDLE the LRU read port follows the incoming index so the victim is available at acceptance.
    assign lru_line_selector  = (r_state == S_IDLE) ? req_index : r_index;
    assign req_ready          = r_req_ready;
    assign lru_update         = r_lru_update;
    assign lru_referenced_set = r_way;
    assign refill_valid       = r_refill_valid;
    assign refill_index       = r_index;
    assign refill_way         = r_way;
    assign resp_valid         = r_resp_valid;
    assign resp_way           = r_way;
    assign hit_count          = r_hit_count;
    assign miss_count         = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_lru_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lru_refill_ctrl
// Description : Directed self-checking bench for lru_refill_ctrl. A
//               transaction-level model predicts every output on every cycle.
//               Literal checks pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lru_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_index;
    logic        req_hit;
    logic [1:0]  req_hit_way;
    logic [7:0]  lru_line_selector;
    logic [1:0]  lru_way;
    logic        lru_update;
    logic [1:0]  lru_referenced_set;
    logic        refill_valid;
    logic        refill_ready;
    logic [7:0]  refill_index;
    logic [1:0]  refill_way;
    logic        refill_done;
    logic        resp_valid;
    logic [1:0]  resp_way;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;

    lru_refill_ctrl #(
        .ASSOCIATIVITY(4), .ENTRIES(256), .INDEX_BITS(8), .OUTPUT_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_hit(req_hit), .req_hit_way(req_hit_way),
        .lru_line_selector(lru_line_selector), .lru_way(lru_way),
        .lru_update(lru_update), .lru_referenced_set(lru_referenced_set),
        .refill_valid(refill_valid), .refill_ready(refill_ready),
        .refill_index(refill_index), .refill_way(refill_way),
        .refill_done(refill_done), .resp_valid(resp_valid), .resp_way(resp_way),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        int s;
        s = int'(v) + 1;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    // ---------------- transaction-level model ----------------
    // One outstanding operation at a time: busy from acceptance until the
    // cycle after its completion pulse; a miss must first hand off its refill
    // request and then see refill_done before it can complete.
    logic        m_busy, m_refill_pending, m_wait_done, m_update;
    logic [7:0]  m_idx;
    logic [1:0]  m_way;
    logic [15:0] m_hits, m_misses;
    logic        preload_go = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_refill_pending <= 1'b0; m_wait_done <= 1'b0; m_update <= 1'b0;
            m_idx <= '0; m_way <= '0; m_hits <= '0; m_misses <= '0;
        end else begin
            if (preload_go) m_hits <= 16'hFFFE;
            if (m_update) begin
                m_update <= 1'b0;
                m_busy   <= 1'b0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    m_busy <= 1'b1;
                    m_idx  <= req_index;
                    if (req_hit) begin
                        m_way    <= req_hit_way;
                        m_update <= 1'b1;
                        m_hits   <= sat_inc(m_hits);
                    end else begin
                        m_way            <= lru_way;
                        m_refill_pending <= 1'b1;
                        m_misses         <= sat_inc(m_misses);
                    end
                end
            end else if (m_refill_pending) begin
                if (refill_ready) begin
                    m_refill_pending <= 1'b0;
                    m_wait_done      <= 1'b1;
                end
            end else if (m_wait_done && refill_done) begin
                m_wait_done <= 1'b0;
                m_update    <= 1'b1;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("lru_line_selector", 32'(lru_line_selector), 32'(m_busy ? m_idx : req_index));
        chk("lru_update", 32'(lru_update), 32'(m_update));
        chk("resp_valid", 32'(resp_valid), 32'(m_update));
        chk("refill_valid", 32'(refill_valid), 32'(m_refill_pending));
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_misses));
        if (m_update) begin
            chk("lru_referenced_set", 32'(lru_referenced_set), 32'(m_way));
            chk("resp_way", 32'(resp_way), 32'(m_way));
        end
        if (m_refill_pending) begin
            chk("refill_index", 32'(refill_index), 32'(m_idx));
            chk("refill_way", 32'(refill_way), 32'(m_way));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [7:0] idx, input logic hit, input logic [1:0] way);
        req_valid = v; req_index = idx; req_hit = hit; req_hit_way = way;
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0; refill_ready = 1'b0; refill_done = 1'b0; lru_way = 2'd0;
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset refill_valid", 32'(refill_valid), 32'd0);
        chk("reset hit_count", 32'(hit_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single hit: index 0x12, way 3.
        set_req(1'b1, 8'h12, 1'b1, 2'd3);
        tick();
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        chk("hit lru_update", 32'(lru_update), 32'd1);
        chk("hit selector", 32'(lru_line_selector), 32'h12);
        chk("hit referenced", 32'(lru_referenced_set), 32'd3);
        chk("hit resp_way", 32'(resp_way), 32'd3);
        chk("hit hit_count", 32'(hit_count), 32'd1);
        tick();

        // Miss: index 0x40, victim 2, refill_ready late by 3 cycles, done 5 cycles after handshake.
        set_req(1'b1, 8'h40, 1'b0, 2'd0);
        lru_way = 2'd2;
        tick();
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        lru_way = 2'd0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (refill_valid && refill_index == 8'h40 && refill_way == 2'd2) cnt++;
            tick();
        end
        refill_ready = 1'b1;
        @(negedge clk);
        if (refill_valid && refill_index == 8'h40 && refill_way == 2'd2) cnt++;
        tick();
        refill_ready = 1'b0;
        chk("miss refill_valid cycles", 32'(cnt), 32'd4);
        repeat (4) tick();
        refill_done = 1'b1;
        @(negedge clk);
        chk("miss no early resp", 32'(resp_valid), 32'd0);
        tick();
        refill_done = 1'b0;
        @(negedge clk);
        chk("miss lru_update", 32'(lru_update), 32'd1);
        chk("miss referenced", 32'(lru_referenced_set), 32'd2);
        chk("miss miss_count", 32'(miss_count), 32'd1);
        tick();

        // Stray refill_done in REFILL_REQ and in the handshake cycle.
        set_req(1'b1, 8'h55, 1'b0, 2'd0);
        lru_way = 2'd1;
        tick();
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        refill_done = 1'b1;
        tick();
        refill_ready = 1'b1;
        tick();
        refill_done = 1'b0; refill_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("stray done ignored", 32'(resp_valid), 32'd0);
        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        @(negedge clk);
        chk("late done resp_valid", 32'(resp_valid), 32'd1);
        chk("late done resp_way", 32'(resp_way), 32'd1);
        tick();

        // Reset while waiting for refill_done.
        set_req(1'b1, 8'h77, 1'b0, 2'd0);
        lru_way = 2'd3;
        tick();
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst refill_valid", 32'(refill_valid), 32'd0);
        chk("rst lru_update", 32'(lru_update), 32'd0);
        chk("rst miss_count", 32'(miss_count), 32'd0);
        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst no pulse", 32'(lru_update), 32'd0);
        set_req(1'b1, 8'h21, 1'b1, 2'd1);
        tick();
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        chk("post-rst hit", 32'(resp_valid), 32'd1);
        chk("post-rst hit_count", 32'(hit_count), 32'd1);
        tick();

        // Back-to-back hits with req_valid held high.
        set_req(1'b1, 8'h30, 1'b1, 2'd2);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (req_valid && req_ready) cnt++;
            tick();
        end
        set_req(1'b0, 8'h00, 1'b0, 2'd0);
        chk("b2b acceptances", 32'(cnt), 32'd4);
        tick();
        tick();

        // Saturation: preload hit counter to 0xFFFE, then three hits.
        @(negedge clk);
        #2;
        force dut.r_hit_count = 16'hFFFE;
        preload_go = 1'b1;
        tick();
        preload_go = 1'b0;
        release dut.r_hit_count;
        repeat (3) begin
            set_req(1'b1, 8'h0F, 1'b1, 2'd0);
            tick();
            set_req(1'b0, 8'h00, 1'b0, 2'd0);
            tick();
        end
        @(negedge clk);
        chk("hit_count saturated", 32'(hit_count), 32'hFFFF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lru_refill_ctrl.md
LRU_REFILL_CTRL -- requirements
Module: lru_refill_ctrl

Interface
REQ-001 Parameters SHALL be:
- ASSOCIATIVITY, default 4, number of cache ways.
- ENTRIES, default 256, number of cache lines tracked.
- INDEX_BITS, default 8, line index width.
- OUTPUT_BITS, default 2, way number width (log2 ASSOCIATIVITY).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup result valid.
- req_ready  out  1  controller can accept a lookup result.
- req_index  in  INDEX_BITS  line index of the lookup.
- req_hit  in  1  lookup hit (1) or miss (0).
- req_hit_way  in  OUTPUT_BITS  way that hit; ignored on a miss.
- lru_line_selector  out  INDEX_BITS  LRU read/update line index.
- lru_way  in  OUTPUT_BITS  victim way from the LRU read port, combinational on lru_line_selector.
- lru_update  out  1  one-cycle LRU update strobe.
- lru_referenced_set  out  OUTPUT_BITS  way reported to the LRU as referenced.
- refill_valid  out  1  refill request valid.
- refill_ready  in  1  memory accepts the refill request.
- refill_index  out  INDEX_BITS  line index to refill.
- refill_way  out  OUTPUT_BITS  victim way to refill.
- refill_done  in  1  one-cycle pulse, refill data written.
- resp_valid  out  1  one-cycle pulse, request completed.
- resp_way  out  OUTPUT_BITS  way now holding the line.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Function
REQ-003 The FSM SHALL have four states: IDLE, REFILL_REQ, REFILL_WAIT, UPDATE.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid & req_ready.
REQ-005 In IDLE, lru_line_selector SHALL equal req_index. In every other state it SHALL equal the captured index.
REQ-006 On acceptance, the block SHALL capture req_index.
REQ-007 On acceptance of a hit, the block SHALL capture req_hit_way and go to UPDATE.
REQ-008 On acceptance of a miss, the block SHALL capture lru_way (sampled in the acceptance cycle) as the victim and go to REFILL_REQ.
REQ-009 In REFILL_REQ:
- refill_valid = 1; refill_index and refill_way hold the captured values, stable until handshake.
- On refill_ready = 1, the block goes to REFILL_WAIT.
REQ-010 refill_done SHALL be ignored in every state except REFILL_WAIT, including a refill_done coincident with the REFILL_REQ handshake.
REQ-011 In REFILL_WAIT, on refill_done = 1 the block SHALL go to UPDATE; it waits indefinitely otherwise.
REQ-012 UPDATE SHALL last exactly one cycle and then return to IDLE. In that cycle:
- lru_update = 1 and lru_referenced_set = captured way (hit way or victim).
- resp_valid = 1 and resp_way = the same way.
REQ-013 Outside UPDATE, lru_update and resp_valid SHALL be 0. Outside REFILL_REQ, refill_valid SHALL be 0.
REQ-014 Hit latency SHALL be: accept at cycle T, lru_update and resp_valid at T+1.
REQ-015 Miss latency SHALL be: accept at T, refill_valid from T+1, UPDATE one cycle after the refill_done cycle.
REQ-016 hit_count SHALL increment on each accepted hit and miss_count on each accepted miss; both saturate at 16'hFFFF and never wrap.
REQ-017 A new request SHALL not be accepted in the UPDATE cycle; the earliest next acceptance is the cycle after UPDATE.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state = IDLE;
- all captured registers, hit_count and miss_count = 0;
- lru_update, refill_valid and resp_valid = 0.
REQ-019 Reset asserted during REFILL_REQ or REFILL_WAIT SHALL abandon the operation with no lru_update or resp_valid pulse. After reset release, req_ready = 1 on the first clock.

Verification
REQ-020 Hit: accept index 0x12, hit, way 3 -> next cycle lru_update = 1, lru_line_selector = 0x12, lru_referenced_set = 3, resp_way = 3; hit_count = 1.
REQ-021 Miss: accept index 0x40, miss, lru_way = 2; refill_ready held 0 for 3 cycles then 1; refill_done 5 cycles later.
- refill_valid is held 4 cycles with refill_index = 0x40 and refill_way = 2.
- lru_update and resp_valid occur one cycle after refill_done, with referenced set 2.
REQ-022 Pulse refill_done during REFILL_REQ and in the handshake cycle -> pulses are ignored; UPDATE occurs only after a later refill_done in REFILL_WAIT.
REQ-023 Assert rst_n low in REFILL_WAIT -> all outputs 0, no lru_update pulse; next request processes normally.
REQ-024 Back-to-back hits with req_valid held high -> accept, UPDATE, accept, UPDATE, one acceptance every 2 cycles.
REQ-025 Preload 16'hFFFE hits, then 3 hits -> hit_count reads 16'hFFFF.
